// File: rtl/kb_pkg.sv
// Shared scan-code constants and decoder state encoding for the keyboard stream.
package kb_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kb_state_e;

endpackage

// File: rtl/scan2ascii_rom.sv
// Combinational PS/2 set-2 make code to ASCII lookup; unmapped codes give 0x00.
module scan2ascii_rom (
  input  logic [7:0] scan_code,
  output logic [7:0] unshifted,
  output logic [7:0] shifted,
  output logic       is_letter
);

  logic [7:0] lower;

  always_comb begin
    lower = 8'h00;
    case (scan_code)
      8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";  8'h23: lower = "d";
      8'h24: lower = "e";  8'h2B: lower = "f";  8'h34: lower = "g";  8'h33: lower = "h";
      8'h43: lower = "i";  8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
      8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";  8'h4D: lower = "p";
      8'h15: lower = "q";  8'h2D: lower = "r";  8'h1B: lower = "s";  8'h2C: lower = "t";
      8'h3C: lower = "u";  8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
      8'h35: lower = "y";  8'h1A: lower = "z";
      default: lower = 8'h00;
    endcase
  end

  always_comb begin
    is_letter = (lower != 8'h00);
    unshifted = 8'h00;
    shifted   = 8'h00;
    if (is_letter) begin
      unshifted = lower;
      shifted   = lower - 8'h20;
    end else begin
      case (scan_code)
        8'h16: begin unshifted = "1"; shifted = "!"; end
        8'h1E: begin unshifted = "2"; shifted = "@"; end
        8'h26: begin unshifted = "3"; shifted = "#"; end
        8'h25: begin unshifted = "4"; shifted = "$"; end
        8'h2E: begin unshifted = "5"; shifted = "%"; end
        8'h36: begin unshifted = "6"; shifted = "^"; end
        8'h3D: begin unshifted = "7"; shifted = "&"; end
        8'h3E: begin unshifted = "8"; shifted = "*"; end
        8'h46: begin unshifted = "9"; shifted = "("; end
        8'h45: begin unshifted = "0"; shifted = ")"; end
        8'h4E: begin unshifted = "-"; shifted = "_"; end
        8'h55: begin unshifted = "="; shifted = "+"; end
        8'h29: begin unshifted = " "; shifted = " "; end
        8'h5A: begin unshifted = 8'h0D; shifted = 8'h0D; end
        default: begin unshifted = 8'h00; shifted = 8'h00; end
      endcase
    end
  end

endmodule

// File: rtl/kb_ascii_stream.sv
// PS/2 scan-code decoder with shift/caps tracking feeding a show-ahead FIFO to the UART.
// Caps lock support is compiled in with KB_CAPS_LOCK_EN.
module kb_ascii_stream
  import kb_pkg::*;
#(
  parameter int         FIFO_AW  = 4,
  parameter logic [7:0] BRK_CODE = SC_BRK,
  parameter logic [7:0] EXT_CODE = SC_EXT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_valid,
  input  logic [7:0]       scan_code,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [7:0]       ascii_out,
  output logic             shift_active,
  output logic             caps_active,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  kb_state_e  state_q, state_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       caps_s;
  logic [7:0] chr_q, chr_d;
  logic       chr_vld_q, chr_vld_d;
  logic [7:0] rom_un, rom_sh;
  logic       rom_letter;

`ifdef KB_CAPS_LOCK_EN
  logic caps_q, caps_d;
  assign caps_s = caps_q;
`else
  assign caps_s = 1'b0;
`endif

  scan2ascii_rom u_rom (
    .scan_code (scan_code),
    .unshifted (rom_un),
    .shifted   (rom_sh),
    .is_letter (rom_letter)
  );

  assign shift_active = lshift_q | rshift_q;
  assign caps_active  = caps_s;

  always_comb begin
    state_d   = state_q;
    lshift_d  = lshift_q;
    rshift_d  = rshift_q;
    chr_d     = 8'h00;
    chr_vld_d = 1'b0;
`ifdef KB_CAPS_LOCK_EN
    caps_d    = caps_q;
`endif
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == BRK_CODE)       state_d  = ST_BRK;
          else if (scan_code == EXT_CODE)  state_d  = ST_EXT;
          else if (scan_code == SC_LSHIFT) lshift_d = 1'b1;
          else if (scan_code == SC_RSHIFT) rshift_d = 1'b1;
`ifdef KB_CAPS_LOCK_EN
          else if (scan_code == SC_CAPS)   caps_d   = ~caps_q;
`endif
          else begin
            // Caps only flips letters; punctuation follows shift alone.
            if (rom_letter) chr_d = (shift_active ^ caps_s) ? rom_sh : rom_un;
            else            chr_d = shift_active ? rom_sh : rom_un;
            chr_vld_d = (chr_d != 8'h00);
          end
        end
        ST_BRK: begin
          if (scan_code == SC_LSHIFT) lshift_d = 1'b0;
          if (scan_code == SC_RSHIFT) rshift_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT:  state_d = (scan_code == BRK_CODE) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      lshift_q  <= 1'b0;
      rshift_q  <= 1'b0;
      chr_q     <= 8'h00;
      chr_vld_q <= 1'b0;
`ifdef KB_CAPS_LOCK_EN
      caps_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lshift_q  <= lshift_d;
      rshift_q  <= rshift_d;
      chr_q     <= chr_d;
      chr_vld_q <= chr_vld_d;
`ifdef KB_CAPS_LOCK_EN
      caps_q    <= caps_d;
`endif
    end
  end

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ovf_q;
  logic               empty, full, push, pop;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == FULL_CNT);
  assign pop        = !empty && !tx_full;
  // A full FIFO still accepts a write when the same cycle pops the head.
  assign push       = chr_vld_q && (!full || pop);
  assign wr_uart    = pop;
  assign ascii_out  = empty ? 8'h00 : mem_q[rptr_q];
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= chr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (chr_vld_q && !push) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kb_ascii_stream.sv
// Directed bench: make/break/extended decoding, shift/caps, FIFO overflow and drain, async reset.
module tb_kb_ascii_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       tx_full = 1'b0;
  logic       wr_uart, shift_active, caps_active, overflow;
  logic [7:0] ascii_out;
  logic [4:0] fifo_count;

  kb_ascii_stream dut (
    .clk          (clk),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .tx_full      (tx_full),
    .wr_uart      (wr_uart),
    .ascii_out    (ascii_out),
    .shift_active (shift_active),
    .caps_active  (caps_active),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] capq[$];
  int         capc[$];
  always @(negedge clk) if (wr_uart) begin
    capq.push_back(ascii_out);
    capc.push_back(cyc);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cap_at(input int i);
    return (capq.size() > i) ? capq[i] : 8'hxx;
  endfunction

  function automatic int capc_at(input int i);
    return (capc.size() > i) ? capc[i] : -1;
  endfunction

  task automatic send(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    @(posedge clk); #1;
    scan_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr();
    capq.delete();
    capc.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr"},    {31'd0, wr_uart},      32'd0);
    check({tag, "_ascii"}, {24'd0, ascii_out},    32'd0);
    check({tag, "_shift"}, {31'd0, shift_active}, 32'd0);
    check({tag, "_caps"},  {31'd0, caps_active},  32'd0);
    check({tag, "_ovf"},   {31'd0, overflow},     32'd0);
    check({tag, "_cnt"},   {27'd0, fifo_count},   32'd0);
  endtask

  initial begin
    int t0;
    int bad;

    // Reset state
    idle(2);
    check_zero_outputs("rst");
    reset = 1'b0;
    idle(1);

    // Make, break, make of 'a': one character, two cycles after the first tick
    clr();
    t0 = cyc;
    send(8'h1C); send(8'hF0); send(8'h1C);
    idle(6);
    check("t1_n",       capq.size(), 1);
    check("t1_char",    cap_at(0), 8'h61);
    check("t1_latency", capc_at(0) - t0, 2);

    // Left shift held: '!' then released: '1'
    clr();
    send(8'h12);
    check("t2_shift_on", shift_active, 1);
    send(8'h16); send(8'hF0); send(8'h16);
    check("t2_shift_held", shift_active, 1);
    send(8'hF0); send(8'h12);
    check("t2_shift_off", shift_active, 0);
    send(8'h16);
    idle(6);
    check("t2_n",  capq.size(), 2);
    check("t2_c0", cap_at(0), 8'h21);
    check("t2_c1", cap_at(1), 8'h31);

`ifdef KB_CAPS_LOCK_EN
    clr();
    send(8'h58);
    check("t3_caps_on", caps_active, 1);
    send(8'hF0); send(8'h58);
    check("t3_caps_brk", caps_active, 1);
    send(8'h1C);
    send(8'h12); send(8'h1C);
    send(8'h16);
    idle(6);
    check("t3_n",  capq.size(), 3);
    check("t3_c0", cap_at(0), 8'h41);
    check("t3_c1", cap_at(1), 8'h61);
    check("t3_c2", cap_at(2), 8'h21);
    send(8'hF0); send(8'h12); send(8'h58);
    check("t3_caps_off", caps_active, 0);
    idle(4);
`else
    clr();
    send(8'h58); send(8'h1C);
    idle(6);
    check("t3_caps_tied", caps_active, 0);
    check("t3_n",  capq.size(), 1);
    check("t3_c0", cap_at(0), 8'h61);
`endif

    // Fill past capacity with the UART stalled, then drain
    clr();
    tx_full = 1'b1;
    repeat (17) begin send(8'h1C); send(8'hF0); send(8'h1C); end
    idle(4);
    check("t4_cnt",  fifo_count, 16);
    check("t4_ovf",  overflow, 1);
    check("t4_wr",   wr_uart, 0);
    check("t4_head", ascii_out, 8'h61);
    check("t4_none", capq.size(), 0);
    t0 = cyc;
    tx_full = 1'b0;
    idle(20);
    check("t4_drain_n", capq.size(), 16);
    bad = 0;
    foreach (capq[i]) if (capq[i] !== 8'h61) bad++;
    check("t4_drain_chars", bad, 0);
    check("t4_first_cyc", capc_at(0) - t0, 0);
    check("t4_consec", capc_at(15) - capc_at(0), 15);
    check("t4_wr_after", wr_uart, 0);
    check("t4_ovf_sticky", overflow, 1);
    check("t4_cnt_after", fifo_count, 0);

    // Extended make and break are discarded
    clr();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h1C);
    idle(6);
    check("t5_n",  capq.size(), 1);
    check("t5_c0", cap_at(0), 8'h61);

    // Reset with shift held and a break pending
    send(8'h12); send(8'hF0);
    reset = 1'b1;
    #1;
    check_zero_outputs("t6_in_rst");
    idle(1);
    reset = 1'b0;
    clr();
    send(8'h1C);
    idle(6);
    check("t6_n",     capq.size(), 1);
    check("t6_c0",    cap_at(0), 8'h61);
    check("t6_shift", shift_active, 0);

    // Push and pop together while full: no drop, count holds
    clr();
    tx_full = 1'b1;
    repeat (16) begin send(8'h1C); send(8'hF0); send(8'h1C); end
    idle(3);
    check("t7_cnt_full", fifo_count, 16);
    check("t7_ovf_pre",  overflow, 0);
    send(8'h32);
    tx_full = 1'b0;
    idle(1);
    check("t7_cnt_same", fifo_count, 16);
    check("t7_ovf_none", overflow, 0);
    idle(24);
    check("t7_drain_n", capq.size(), 17);
    check("t7_last",    cap_at(16), 8'h62);
    check("t7_ovf_end", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kb_ascii_stream.md
# kb_ascii_stream

Parametrised keyboard-to-serial character stream. Consumes raw PS/2 scan-code bytes from the keyboard receiver, tracks make/break/extended prefixes and modifier state, and translates make codes to ASCII. It buffers characters in an internal FIFO and drives the UART transmitter's write handshake. It sits between the PS/2 receiver and the UART, replacing the fixed "scan code in, character out" path with shift-aware, flow-controlled streaming.

## Interface
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW characters.
- `BRK_CODE`, 8'hF0: break prefix byte.
- `EXT_CODE`, 8'hE0: extended prefix byte.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `scan_valid`  in  1  one-cycle tick; `scan_code` is valid this cycle.
- `scan_code`  in  8  scan-code byte from the PS/2 receiver.
- `tx_full`  in  1  UART transmit buffer full.
- `wr_uart`  out  1  write strobe to the UART; a character is consumed every cycle it is high.
- `ascii_out`  out  8  FIFO head character (show-ahead).
- `shift_active`  out  1  left or right shift is held.
- `caps_active`  out  1  caps-lock latched. Constant 0 when the feature is compiled out.
- `overflow`  out  1  sticky flag: a character was dropped because the FIFO was full.
- `fifo_count`  out  FIFO_AW+1  number of buffered characters.

## Operation
- Decoder FSM: IDLE, BRK, EXT, EXT_BRK. It advances only on `scan_valid`.
- **IDLE**
  - `BRK_CODE` → BRK.
  - `EXT_CODE` → EXT.
  - 0x12 sets `lshift`; 0x59 sets `rshift`. No character is produced.
  - 0x58 toggles caps (when enabled). No character is produced.
  - Any other byte is looked up. A non-zero result is pushed to the FIFO; a zero result is dropped silently.
- **BRK**
  - 0x12 clears `lshift`; 0x59 clears `rshift`.
  - Other bytes are ignored.
  - → IDLE.
- **EXT**
  - `BRK_CODE` → EXT_BRK.
  - Any other byte is discarded (extended keys produce no ASCII) → IDLE.
- **EXT_BRK**: discard the byte → IDLE.
- `shift_active` = `lshift | rshift`.
- Case rules:
  - Letters use the upper-case table when `shift_active ^ caps_active`.
  - Non-letters use the shifted table when `shift_active` only.
- Output side:
  - `wr_uart` = FIFO not empty AND NOT `tx_full`.
  - The FIFO pops in every cycle `wr_uart` is high.
  - `ascii_out` = 0 when the FIFO is empty.
- FIFO full boundaries:
  - Push without a simultaneous pop: the character is dropped and `overflow` is set. `overflow` clears only on reset.
  - Push and pop in the same cycle while full: both are performed; count is unchanged; no overflow.
- Pointers wrap modulo 2^FIFO_AW. `fifo_count` saturates logically at 2^FIFO_AW.

## Timing
- All outputs reset to 0: FSM = IDLE, shift/caps flags = 0, FIFO empty, `overflow` = 0.
- Reset is asynchronous and may arrive mid-sequence. A pending prefix is forgotten and the pipeline register is cleared.
- Latency:
  - `scan_valid` in cycle n → lookup registered at n+1 → FIFO write at end of n+1.
  - `wr_uart` can be high at n+2 at the earliest.
- `scan_valid` on back-to-back cycles is supported at full rate.
- `wr_uart` is combinational from registered FIFO state and `tx_full`. There is no other combinational input-to-output path.

## Configuration
- `KB_CAPS_LOCK_EN` defined:
  - 0x58 make toggles `caps_active`; its break is ignored through the BRK state.
  - Caps affects letters only.
- `KB_CAPS_LOCK_EN` undefined:
  - 0x58 is treated as an unmapped key (dropped).
  - `caps_active` is tied to 0.

## Structure
- Package `kb_pkg`:
  - Scan-code constants: 0x12, 0x59, 0x58, default `BRK_CODE`/`EXT_CODE`.
  - FSM state enum.
- Sub-module `scan2ascii_rom`:
  - Purely combinational.
  - Input: scan code.
  - Outputs: `unshifted[7:0]`, `shifted[7:0]`, `is_letter`; 0x00 for unmapped codes.
- FIFO is inline: register array, read/write pointers, count.

## Test plan
- 1C, F0, 1C → exactly one character 0x61 emitted. `wr_uart` pulses one cycle, at the earliest 2 cycles after the first tick.
- 12, 16, F0, 16, F0, 12, 16 → characters 0x21 then 0x31. `shift_active` is 1 between the 12 make and its break.
- With `KB_CAPS_LOCK_EN`: 58, F0, 58, 1C → 0x41; then 12, 1C → 0x61; then 16 → 0x21. Without the macro: 58, 1C → 0x61 only.
- `tx_full`=1, FIFO_AW=4, 17 make codes of 1C (with breaks) → `fifo_count`=16 and `overflow`=1. Release `tx_full` → 16 × 0x61 in consecutive cycles, then `wr_uart`=0 and `overflow` remains 1.
- E0, 75, E0, F0, 75 then 1C → only 0x61 emitted; FSM returns to IDLE after each sequence.
- 12, F0, then assert `reset` for 1 cycle, then 1C → 0x61 (not a release, not shifted); all outputs 0 during reset.
